// File: rtl/fp_pkg.sv
// Shared floating-point constants and bundles.
// Used by the multiplier back-end and rounding helpers.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int PROD_W = 48;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [30:0] FP_INF31   = 31'h7F800000;

    // Internal exponent is 10-bit signed so that
    // E_mul in [-128,127] plus bias and carries never wraps.
    localparam int IEXP_W = 10;

    typedef struct packed {
        logic [MAN_W-1:0]  mant;
        logic              g;
        logic              s;
        logic [IEXP_W-1:0] e;
        logic [30:0]       op2;
    } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even, re-bias carry and saturation.
// Ports: mant_i/g_i/s_i/e1_i in; res_o {exp,mant}, ovf_o, unf_o out.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0]         mant_i,
    input  logic                     g_i,
    input  logic                     s_i,
    input  logic signed [IEXP_W-1:0] e1_i,
    output logic [30:0]              res_o,
    output logic                     ovf_o,
    output logic                     unf_o
);

    localparam logic signed [IEXP_W-1:0] EMAX = IEXP_W'(FP_EXP_MAX);

    logic                     up;
    logic [MAN_W:0]           mant_r;
    logic [MAN_W-1:0]         mant_f;
    logic signed [IEXP_W-1:0] e2;

    always_comb begin
        up     = g_i & (s_i | mant_i[0]);
        mant_r = {1'b0, mant_i} + {{MAN_W{1'b0}}, up};
        // Carry out of the mantissa: value is 2.0, so bump exponent.
        mant_f = mant_r[MAN_W] ? '0 : mant_r[MAN_W-1:0];
        e2     = e1_i + $signed({{(IEXP_W-1){1'b0}}, mant_r[MAN_W]});

        res_o = '0;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (e2 >= EMAX) begin
            res_o = FP_INF31;
            ovf_o = 1'b1;
        end else if (e2 <= 0) begin
            unf_o = 1'b1;
        end else begin
            res_o = {e2[EXP_W-1:0], mant_f};
        end
    end

endmodule

// File: rtl/fp_mul_normalize_pipe.sv
// FP multiplier back-end: normalize, RNE round, re-bias, saturate.
// Ports: clk/rst, valid + M_mul/E_mul/float_in_2 in;
// float_out, float_out_2, ovf, unf, ready out (2-cycle latency).
module fp_mul_normalize_pipe
    import fp_pkg::*;
#(
    parameter int BIAS = FP_BIAS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [PROD_W-1:0] M_mul,
    input  logic [EXP_W-1:0]  E_mul,
    input  logic [30:0]       float_in_2,
    output logic [30:0]       float_out,
    output logic [30:0]       float_out_2,
    output logic              ovf,
    output logic              unf,
    output logic              ready
);

    s1_t         s1_d, s1_q;
    logic        s1_vld_q;
    logic [30:0] out_q, out2_q;
    logic        ovf_q, unf_q, ready_q;

    logic [30:0] rnd_res;
    logic        rnd_ovf, rnd_unf;
    logic        shift;

    // Stage 1: product is in [1,4); pick the window under the leading 1.
    always_comb begin
        shift   = M_mul[47];
        s1_d    = '0;
        s1_d.op2 = float_in_2;
        if (shift) begin
            s1_d.mant = M_mul[46:24];
            s1_d.g    = M_mul[23];
            s1_d.s    = |M_mul[22:0];
        end else begin
            s1_d.mant = M_mul[45:23];
            s1_d.g    = M_mul[22];
            s1_d.s    = |M_mul[21:0];
        end
        s1_d.e = {{(IEXP_W-EXP_W){E_mul[EXP_W-1]}}, E_mul}
               + {{(IEXP_W-1){1'b0}}, shift}
               + IEXP_W'(BIAS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= valid;
            if (valid) s1_q <= s1_d;
        end
    end

    fp_round_rne u_round (
        .mant_i (s1_q.mant),
        .g_i    (s1_q.g),
        .s_i    (s1_q.s),
        .e1_i   ($signed(s1_q.e)),
        .res_o  (rnd_res),
        .ovf_o  (rnd_ovf),
        .unf_o  (rnd_unf)
    );

    // Stage 2: outputs hold the last result between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            out2_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_q  <= rnd_res;
                out2_q <= s1_q.op2;
                ovf_q  <= rnd_ovf;
                unf_q  <= rnd_unf;
            end
        end
    end

    assign float_out   = out_q;
    assign float_out_2 = out2_q;
    assign ovf         = ovf_q;
    assign unf         = unf_q;
    assign ready       = ready_q;

endmodule
